// File: rtl/acc_fp_norm.sv
// Accumulator back end: 2-stage valid/ready pipeline that normalizes an aligned mantissa sum
// and packs it as {sign, exp, man}. Define ACC_FP_NORM_RNE_EN for round-to-nearest-even.
module acc_fp_norm #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 11,
  parameter int unsigned SUM_W = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_sgn,
  input  logic [EXP_W-1:0]             in_exp,
  input  logic [SUM_W-1:0]             in_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_W+MAN_W:0]         out_ops,
  output logic                         out_ovf,
  output logic                         out_uf,
  output logic                         sticky_ovf,
  output logic                         sticky_uf,
  input  logic                         clr_sticky
);

  localparam int unsigned LEAD_W = $clog2(SUM_W);
  localparam int unsigned GRD_W  = SUM_W - 1 - MAN_W;
  localparam int unsigned XW     = EXP_W + 2;

  logic             s1_valid_q;
  logic             s1_sgn_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [SUM_W-1:0] s1_mag_q;

  logic             s2_adv;
  logic             neg;
  logic [SUM_W-1:0] mag_d;
  logic             sgn_d;

  logic [LEAD_W-1:0]    lead;
  logic [SUM_W-1:0]     norm;
  logic [MAN_W-1:0]     man;
  logic signed [XW-1:0] exp_n;
  logic                 ovf_d;
  logic                 uf_d;
  logic [EXP_W+MAN_W:0] ops_d;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    neg   = in_sgn[1] && in_sum[SUM_W-1];
    mag_d = neg ? (~in_sum + SUM_W'(1)) : in_sum;
    sgn_d = neg ? ~in_sgn[0] : in_sgn[0];
  end

`ifdef ACC_FP_NORM_RNE_EN
  logic [GRD_W-1:0] guard;
  logic             rnd_up;
  logic             man_co;
`else
  logic             unused_grd;
  assign unused_grd = ^norm[GRD_W-1:0];
`endif
  logic unused_lead;
  assign unused_lead = norm[SUM_W-1];

  // Shift so the leading one always lands in the top bit; the carry and non-carry cases
  // then share one mantissa slice and one guard field.
  always_comb begin
    lead = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (s1_mag_q[i]) lead = LEAD_W'(i);
    end
    norm  = s1_mag_q << (LEAD_W'(SUM_W - 1) - lead);
    man   = norm[SUM_W-2 -: MAN_W];
    exp_n = XW'(s1_exp_q) + XW'(lead) - XW'(SUM_W - 2);
`ifdef ACC_FP_NORM_RNE_EN
    guard  = norm[GRD_W-1:0];
    rnd_up = (guard > {1'b1, {(GRD_W-1){1'b0}}}) ||
             ((guard == {1'b1, {(GRD_W-1){1'b0}}}) && man[0]);
    {man_co, man} = {1'b0, man} + (MAN_W+1)'(rnd_up);
    if (man_co) exp_n = exp_n + XW'(1);
`endif
    ovf_d = 1'b0;
    uf_d  = 1'b0;
    ops_d = '0;
    if (s1_mag_q != '0) begin
      if (!exp_n[XW-1] && exp_n[XW-2]) begin
        ovf_d = 1'b1;
        ops_d = {s1_sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      end else if (exp_n[XW-1] || ((exp_n == '0) && (man == '0))) begin
        uf_d = 1'b1;
      end else begin
        ops_d = {s1_sgn_q, exp_n[EXP_W-1:0], man};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_mag_q   <= '0;
      out_valid  <= 1'b0;
      out_ops    <= '0;
      out_ovf    <= 1'b0;
      out_uf     <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_uf  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sgn_q <= sgn_d;
          s1_exp_q <= in_exp;
          s1_mag_q <= mag_d;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid_q;
        if (s1_valid_q) begin
          out_ops <= ops_d;
          out_ovf <= ovf_d;
          out_uf  <= uf_d;
        end
      end
      if (clr_sticky) begin
        sticky_ovf <= 1'b0;
        sticky_uf  <= 1'b0;
      end else if (s2_adv && s1_valid_q) begin
        sticky_ovf <= sticky_ovf | ovf_d;
        sticky_uf  <= sticky_uf | uf_d;
      end
    end
  end

endmodule

// File: tb/tb_acc_fp_norm.sv
// Self-checking bench for acc_fp_norm: directed vectors plus randomized traffic scored
// against an arithmetic reference model.
module tb_acc_fp_norm;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sgn;
  logic [3:0]  in_exp;
  logic [16:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ops;
  logic        out_ovf;
  logic        out_uf;
  logic        sticky_ovf;
  logic        sticky_uf;
  logic        clr_sticky;

  acc_fp_norm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sgn     (in_sgn),
    .in_exp     (in_exp),
    .in_sum     (in_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ops    (out_ops),
    .out_ovf    (out_ovf),
    .out_uf     (out_uf),
    .sticky_ovf (sticky_ovf),
    .sticky_uf  (sticky_uf),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ops;
    logic        ovf;
    logic        uf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int cons_cnt = 0;

  // Value-level model: interpret the sum as a number, scale the mantissa by division.
  function automatic exp_t model(input logic [1:0] sg, input logic [3:0] ex,
                                 input logic [16:0] sm);
    exp_t   r;
    longint v, pw, mq;
    int     p, e;
    logic   s;
    r.ops = 16'h0000;
    r.ovf = 1'b0;
    r.uf  = 1'b0;
    v = longint'(sm);
    if (sg[1] && sm[16]) v = v - 131072;
    s = sg[0];
    if (v < 0) begin
      v = -v;
      s = !s;
    end
    if (v == 0) return r;
    p = 0;
    while ((longint'(1) << (p + 1)) <= v) p++;
    e  = int'(ex) + p - 15;
    pw = longint'(1) << p;
    mq = (v * 2048) / pw;
`ifdef ACC_FP_NORM_RNE_EN
    begin
      longint rem;
      rem = (v * 2048) % pw;
      if ((2 * rem > pw) || ((2 * rem == pw) && (mq % 2 == 1))) mq++;
    end
`endif
    if (mq == 4096) begin
      mq = 2048;
      e++;
    end
    if (e > 15) begin
      r.ops = {s, 15'h7FFF};
      r.ovf = 1'b1;
    end else if ((e < 0) || ((e == 0) && (mq == 2048))) begin
      r.uf = 1'b1;
    end else begin
      r.ops = {s, 4'(e), 11'(mq - 2048)};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Sample the handshake just after the negedge drive, then advance one full cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        cons_cnt++;
        if (q.size() == 0) begin
          chk("sb_unexpected_out", 32'(out_ops), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("sb_ops", 32'(out_ops), 32'(e.ops));
          chk("sb_ovf", 32'(out_ovf), 32'(e.ovf));
          chk("sb_uf", 32'(out_uf), 32'(e.uf));
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        q.push_back(model(in_sgn, in_exp, in_sum));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [16:0] rnd_sum();
    int     k;
    longint mask;
    k    = $urandom_range(0, 17);
    mask = (longint'(1) << k) - 1;
    return 17'(longint'($urandom) & mask);
  endfunction

  task automatic rnd_beat();
    in_sgn = 2'($urandom);
    in_exp = 4'($urandom);
    in_sum = rnd_sum();
  endtask

  task automatic send_dir(input string tag, input logic [1:0] sg, input logic [3:0] ex,
                          input logic [16:0] sm, input logic [15:0] e_ops,
                          input logic e_ovf, input logic e_uf);
    in_valid = 1'b1;
    in_sgn   = sg;
    in_exp   = ex;
    in_sum   = sm;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid_n1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid_n2"}, 32'(out_valid), 32'd1);
    chk({tag, "_ops"}, 32'(out_ops), 32'(e_ops));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(e_ovf));
    chk({tag, "_uf"}, 32'(out_uf), 32'(e_uf));
  endtask

  initial begin
    int a0, c0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sgn     = 2'b00;
    in_exp     = 4'd0;
    in_sum     = 17'd0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ops", 32'(out_ops), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_uf", 32'(out_uf), 32'd0);
    chk("rst_sticky_ovf", 32'(sticky_ovf), 32'd0);
    chk("rst_sticky_uf", 32'(sticky_uf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    send_dir("norm", 2'b00, 4'd5, 17'h08000, 16'h2800, 1'b0, 1'b0);
    tick();
    send_dir("carry", 2'b00, 4'd5, 17'h10000, 16'h3000, 1'b0, 1'b0);
    tick();
    send_dir("sat", 2'b00, 4'd15, 17'h10000, 16'h7FFF, 1'b1, 1'b0);
    chk("sat_sticky_set", 32'(sticky_ovf), 32'd1);
    tick();
    chk("sat_sticky_hold", 32'(sticky_ovf), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sat_sticky_clr", 32'(sticky_ovf), 32'd0);
    send_dir("neg", 2'b10, 4'd5, 17'h1F000, 16'h9000, 1'b0, 1'b0);
    tick();
    send_dir("zero", 2'b11, 4'd5, 17'h00000, 16'h0000, 1'b0, 1'b0);
    tick();
    send_dir("uflow", 2'b00, 4'd1, 17'h00100, 16'h0000, 1'b0, 1'b1);
    chk("uflow_sticky", 32'(sticky_uf), 32'd1);
    tick();
`ifdef ACC_FP_NORM_RNE_EN
    send_dir("round", 2'b00, 4'd5, 17'h08018, 16'h2802, 1'b0, 1'b0);
`else
    send_dir("round", 2'b00, 4'd5, 17'h08018, 16'h2801, 1'b0, 1'b0);
`endif
    tick();
    clr_sticky = 1'b1;
    send_dir("clr_wins", 2'b01, 4'd15, 17'h10000, 16'hFFFF, 1'b1, 1'b0);
    chk("clr_wins_sticky", 32'(sticky_ovf), 32'd0);
    tick();
    clr_sticky = 1'b0;

    // Backpressure: only the two pipeline slots may fill.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      rnd_beat();
      tick();
    end
    chk("bp_accepted", 32'(acc_cnt - a0), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_ops_held", 32'(out_ops), 32'(q[0].ops));
    out_ready = 1'b1;
    c0 = cons_cnt;
    for (int i = 0; i < 6; i++) begin
      rnd_beat();
      tick();
    end
    chk("bp_release_rate", 32'(cons_cnt - c0), 32'd6);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("bp_drained", 32'(q.size()), 32'd0);

    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      clr_sticky = ($urandom % 16) == 0;
      rnd_beat();
      tick();
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_no_loss_dup", 32'(acc_cnt), 32'(cons_cnt));

    // Reset while both stages hold beats.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rnd_beat();
    tick();
    rnd_beat();
    tick();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_ops", 32'(out_ops), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mid_post_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
